// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Shares one single-port synchronous SRAM (1-cycle read latency) among NREQ
//   requesters. Round-robin arbitration with an optional per-requester burst
//   lock. At most one memory access is issued per cycle, and read data is routed
//   back to the requester that issued the read.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req/lock/we       per-requester request, lock-hold and write-select
//   addr/wdata        flattened per-requester address / write data
//   gnt               one-hot grant; the access happens in this cycle
//   rvalid/rdata      one-hot read-return strobe; shared read data bus
//   mem_*             single-port memory interface (read data one cycle later)
module sram_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One extra bit so that ptr+offset can exceed NREQ-1 before the wrap.
  localparam int SW = PW + 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]   prio_ptr_reg, prio_ptr_next;
  logic            locked_reg, locked_next;
  logic [PW-1:0]   lock_owner_reg, lock_owner_next;
  logic [NREQ-1:0] rd_owner_reg, rd_owner_next;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*AW +: AW];
      assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   win_c;
  logic            found_c;
  logic [SW-1:0]   scan_sum;
  logic [PW-1:0]   scan_idx;

  // Grant selection. A held lock wins outright; otherwise scan from prio_ptr
  // upward with wrap. The wrap is a conditional subtract, so an index >= NREQ
  // is never produced even when NREQ is not a power of two.
  always_comb begin
    gnt_c    = '0;
    win_c    = '0;
    found_c  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    if (!rst) begin
      if (locked_reg && req[lock_owner_reg]) begin
        gnt_c[lock_owner_reg] = 1'b1;
        win_c                 = lock_owner_reg;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          scan_sum = {1'b0, prio_ptr_reg} + SW'(k);
          if (scan_sum >= SW'(NREQ)) begin
            scan_sum = scan_sum - SW'(NREQ);
          end
          scan_idx = scan_sum[PW-1:0];
          if (!found_c && req[scan_idx]) begin
            found_c         = 1'b1;
            gnt_c[scan_idx] = 1'b1;
            win_c           = scan_idx;
          end
        end
      end
    end
  end

  logic any_gnt;
  assign any_gnt = |gnt_c;

  assign gnt       = gnt_c;
  assign mem_en    = any_gnt;
  assign mem_we    = any_gnt & we[win_c];
  assign mem_addr  = any_gnt ? addr_arr[win_c]  : '0;
  assign mem_wdata = any_gnt ? wdata_arr[win_c] : '0;

  // rd_owner still holds a pre-reset read during the first reset cycle; mask
  // it so a read in flight at reset never returns.
  assign rvalid = rst ? '0 : rd_owner_reg;
  assign rdata  = mem_rdata;

  always_comb begin
    prio_ptr_next   = prio_ptr_reg;
    lock_owner_next = lock_owner_reg;
    if (any_gnt) begin
      prio_ptr_next   = (win_c == LAST) ? '0 : win_c + PW'(1);
      lock_owner_next = win_c;
    end
    // Lock persists only while the winner keeps lock asserted. A dropped
    // request from the owner lets another requester win via RR, and that
    // winner's own lock bit then decides.
    locked_next   = any_gnt & lock[win_c];
    rd_owner_next = (any_gnt && !we[win_c]) ? gnt_c : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_reg   <= '0;
      locked_reg     <= 1'b0;
      lock_owner_reg <= '0;
      rd_owner_reg   <= '0;
    end else begin
      prio_ptr_reg   <= prio_ptr_next;
      locked_reg     <= locked_next;
      lock_owner_reg <= lock_owner_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Testbench for sram_rr_arbiter: directed scenarios plus a randomized run
// checked against an integer-level reference model and a reference memory.
module tb_sram_rr_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, lock, we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      gnt, rvalid;
  logic [DW-1:0]        rdata;
  logic                 mem_en, mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata, mem_rdata;

  logic [DW-1:0]        sram [0:255];

  int errors = 0;
  int checks = 0;

  // Reference model state (plain integers; -1 means "none")
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  int            m_rd_owner;
  logic [DW-1:0] m_rd_data;
  bit            m_rd_known;
  logic [DW-1:0] refmem [0:255];
  bit            refvalid [0:255];

  sram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Read-first synchronous single-port memory
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      mem_rdata <= sram[mem_addr];
    end
  end

  // Winner according to the arbitration rules, -1 if nobody is granted
  function automatic int m_winner();
    if (rst) return -1;
    if (m_locked && req[m_owner]) return m_owner;
    for (int k = 0; k < NREQ; k++)
      if (req[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int idx);
    logic [NREQ-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Advance the model by one clock with the current inputs, then clock the DUT
  task automatic tick();
    int w;
    int a;
    w = m_winner();
    if (rst) begin
      m_ptr = 0; m_locked = 0; m_rd_owner = -1;
    end else if (w >= 0) begin
      m_ptr    = (w + 1) % NREQ;
      m_locked = lock[w];
      m_owner  = w;
      a        = int'(addr[w*AW +: AW]);
      if (we[w]) begin
        refmem[a]   = wdata[w*DW +: DW];
        refvalid[a] = 1'b1;
        m_rd_owner  = -1;
      end else begin
        m_rd_owner = w;
        m_rd_data  = refmem[a];
        m_rd_known = refvalid[a];
      end
    end else begin
      m_locked   = 0;
      m_rd_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input bit l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]          = r;
    we[i]           = w;
    lock[i]         = l;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = '0; lock = '0; we = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; lock = '0; we = '0; addr = '0; wdata = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem: got en=%b we=%b want 0 0", mem_en, mem_we); end
      checks++;
      if (rvalid !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b want 0001", gnt); end
    tick();
    req = '0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_fairness();
    logic [3:0] seq [8];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    apply_reset();
    req = 4'b1111; lock = '0; we = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (gnt !== seq[c]) begin errors++; $display("FAIL fair_gnt[%0d]: got %b want %b", c, gnt, seq[c]); end
      tick();
    end
    req = '0;
    tick();
    $display("test_fairness done");
  endtask

  task automatic test_read_latency();
    apply_reset();
    set_req(3, 1, 1, 0, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000 || mem_we !== 1'b1) begin errors++; $display("FAIL preload: got gnt=%b we=%b want 1000 1", gnt, mem_we); end
    tick();
    set_req(3, 0, 0, 0, 8'h00, 32'h0);
    set_req(1, 1, 0, 0, 8'h10, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010 || mem_addr !== 8'h10 || mem_en !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rd_issue: got gnt=%b addr=%h en=%b we=%b want 0010 10 1 0", gnt, mem_addr, mem_en, mem_we);
    end
    checks++;
    if (rvalid !== 4'b0000) begin errors++; $display("FAIL rd_early: got rvalid=%b want 0000", rvalid); end
    tick();
    set_req(1, 0, 0, 0, 8'h00, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0010 || rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_return: got rvalid=%b rdata=%h want 0010 deadbeef", rvalid, rdata);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL idle_mem: got en=%b addr=%h wdata=%h want 0 00 0", mem_en, mem_addr, mem_wdata);
    end
    tick();
    $display("test_read_latency done");
  endtask

  task automatic test_write_read();
    apply_reset();
    set_req(2, 1, 1, 0, 8'h05, 32'h1234);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || mem_wdata !== 32'h1234) begin errors++; $display("FAIL wr_issue: got gnt=%b wdata=%h want 0100 1234", gnt, mem_wdata); end
    tick();
    set_req(2, 1, 0, 0, 8'h05, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0000) begin errors++; $display("FAIL wr_no_rvalid: got %b want 0000", rvalid); end
    tick();
    set_req(2, 1, 1, 0, 8'h05, 32'h5678);
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0100 || rdata !== 32'h1234) begin errors++; $display("FAIL wr_rd_data: got rvalid=%b rdata=%h want 0100 1234", rvalid, rdata); end
    checks++;
    if (gnt !== 4'b0100 || mem_we !== 1'b1) begin errors++; $display("FAIL b2b_grant: got gnt=%b we=%b want 0100 1", gnt, mem_we); end
    tick();
    set_req(2, 1, 0, 0, 8'h05, 32'h0);
    tick();
    set_req(2, 0, 0, 0, 8'h00, 32'h0);
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0100 || rdata !== 32'h5678) begin errors++; $display("FAIL rewrite_data: got rvalid=%b rdata=%h want 0100 5678", rvalid, rdata); end
    tick();
    $display("test_write_read done");
  endtask

  task automatic test_lock();
    logic [3:0] seq [4];
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    apply_reset();
    set_req(0, 1, 0, 1, 8'h01, 32'h0);
    set_req(1, 1, 0, 0, 8'h02, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) lock[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt !== seq[c]) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want %b", c, gnt, seq[c]); end
      tick();
    end
    req = '0; lock = '0;
    tick();
    $display("test_lock done");
  endtask

  task automatic test_reset_midread();
    apply_reset();
    set_req(2, 1, 0, 0, 8'h05, 32'h0);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
    tick();
    rst = 1'b1; req = '0;
    @(negedge clk);
    checks++;
    if (rvalid !== 4'b0000) begin errors++; $display("FAIL mid_rvalid: got %b want 0000", rvalid); end
    tick();
    rst = 1'b0; req = 4'b1111; we = '0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || rvalid !== 4'b0000) begin errors++; $display("FAIL mid_release: got gnt=%b rvalid=%b want 0001 0000", gnt, rvalid); end
    tick();
    req = '0;
    tick();
    $display("test_reset_midread done");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] gp;
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] er;
    int w;
    apply_reset();
    gp = '0;
    for (int c = 0; c < 400; c++) begin
      // A requester keeps its request stable until it has been granted
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || gp[i]) begin
          set_req(i, ($urandom_range(0, 9) < 6), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  AW'($urandom_range(0, 15)), $urandom);
        end
      end
      rst = ($urandom_range(0, 39) == 0);
      @(negedge clk);
      w  = m_winner();
      eg = onehot(w);
      er = rst ? '0 : onehot(m_rd_owner);
      checks++;
      if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, gnt, eg); end
      checks++;
      if (mem_en !== (w >= 0)) begin errors++; $display("FAIL rnd_en c=%0d: got %b want %b", c, mem_en, (w >= 0)); end
      checks++;
      if (w >= 0) begin
        if (mem_we !== we[w] || mem_addr !== addr[w*AW +: AW] || mem_wdata !== wdata[w*DW +: DW]) begin
          errors++; $display("FAIL rnd_mem c=%0d: got we=%b addr=%h wdata=%h want %b %h %h", c, mem_we, mem_addr, mem_wdata, we[w], addr[w*AW +: AW], wdata[w*DW +: DW]);
        end
      end else if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        errors++; $display("FAIL rnd_idle c=%0d: got we=%b addr=%h wdata=%h want zeros", c, mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if (rvalid !== er) begin errors++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, rvalid, er); end
      if (er != '0 && m_rd_known) begin
        checks++;
        if (rdata !== m_rd_data) begin errors++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rdata, m_rd_data); end
      end
      gp = gnt;
      tick();
    end
    rst = 1'b0; req = '0; lock = '0;
    tick();
    $display("test_random done");
  endtask

  initial begin
    m_ptr = 0; m_locked = 0; m_owner = 0; m_rd_owner = -1;
    m_rd_data = '0; m_rd_known = 0;
    for (int i = 0; i < 256; i++) begin
      refmem[i]   = '0;
      refvalid[i] = 1'b0;
    end
    test_reset();
    test_fairness();
    test_read_latency();
    test_write_read();
    test_lock();
    test_reset_midread();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
